// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters gated by pix_en, with
// registered sync/blanking decodes aligned to the counters they describe.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
    $error("vga_timing_gen: visible, porch and sync parameters must all be >= 1");
  end

  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_STOP    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_STOP    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Decoding from the next counter values keeps every registered flag in
  // the same cycle as the count it belongs to.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end
    end
    hsync_d = (h_d >= HS_START && h_d <= HS_STOP) ? HS_POL : ~HS_POL;
    vsync_d = (v_d >= VS_START && v_d <= VS_STOP) ? VS_POL : ~VS_POL;
    video_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  // Reset parks the raster on its last pixel so the first enabled cycle
  // wraps into pixel (0,0) with a frame_end strobe.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      video_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
    end
  end

  assign h_count   = h_q;
  assign v_count   = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_q;
  assign line_end  = rst_n & pix_en & h_wrap;
  assign frame_end = line_end & v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing on one instance,
// a tiny 12x7 raster with positive sync polarity on a second.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [15:0] h_count, v_count;
  logic        hsync, vsync, video_on, line_end, frame_end;

  logic        rst_s = 1'b0;
  logic        pix_s = 1'b0;
  logic [7:0]  h_s, v_s;
  logic        hsync_s, vsync_s, video_s, line_end_s, frame_end_s;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk_25MHz(clk), .rst_n(rst_n), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .line_end(line_end), .frame_end(frame_end)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8)
  ) u_small (
    .clk_25MHz(clk), .rst_n(rst_s), .pix_en(pix_s),
    .h_count(h_s), .v_count(v_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_s), .line_end(line_end_s), .frame_end(frame_end_s)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic cyc(input logic r, input logic e);
    @(negedge clk);
    rst_n  = r;
    pix_en = e;
    #1;
  endtask

  task automatic cyc_s(input logic r, input logic e);
    @(negedge clk);
    rst_s = r;
    pix_s = e;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq_err, von_cnt, hs_cnt, hs_first, hs_last, vs_low, le_cnt, le_first, le_second;
    int hold_err, step_err, strobe_err;
    int ph, pv, phs, pvs, pvo, pen;
    bit found;
    int fe_first, fe_second, fe_cnt, skew_err, vo_s, vs_cnt, vs_min, vs_max;
    int hs_min, hs_max, h_max, v_max;
    bit exp_hs, exp_vs, exp_vo;

    // ---------------- default instance: reset ----------------
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check_val("rst_h_count", h_count, 799);
    check_val("rst_v_count", v_count, 524);
    check_val("rst_hsync", hsync, 1);
    check_val("rst_vsync", vsync, 1);
    check_val("rst_video_on", video_on, 0);
    check_val("rst_line_end_gated", line_end, 0);
    check_val("rst_frame_end_gated", frame_end, 0);

    cyc(1'b1, 1'b1);
    check_val("first_line_end", line_end, 1);
    check_val("first_frame_end", frame_end, 1);
    cyc(1'b1, 1'b1);
    check_val("start_h_count", h_count, 0);
    check_val("start_v_count", v_count, 0);
    check_val("start_video_on", video_on, 1);
    check_val("start_hsync", hsync, 1);
    check_val("start_vsync", vsync, 1);
    check_val("start_line_end", line_end, 0);

    // ---------------- lines 0 and 1 ----------------
    seq_err = 0; von_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    vs_low = 0; le_cnt = 0; le_first = -1; le_second = -1;
    for (int k = 0; k < 1600; k++) begin
      if (k != 0) cyc(1'b1, 1'b1);
      if (int'(h_count) != k % 800 || int'(v_count) != k / 800) seq_err++;
      if (!vsync) vs_low++;
      if (k < 800) begin
        if (video_on) von_cnt++;
        if (!hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
      end
      if (line_end) begin
        le_cnt++;
        if (le_first < 0) le_first = k;
        else if (le_second < 0) le_second = k;
      end
    end
    check_val("line_count_seq_err", seq_err, 0);
    check_val("line0_video_cycles", von_cnt, 640);
    check_val("line0_hsync_cycles", hs_cnt, 96);
    check_val("line0_hsync_first_h", hs_first, 656);
    check_val("line0_hsync_last_h", hs_last, 751);
    check_val("lines_vsync_low", vs_low, 0);
    check_val("line_end_first_h", le_first, 799);
    check_val("line_end_period", le_second - le_first, 800);
    check_val("line_end_count", le_cnt, 2);

    // ---------------- pix_en toggling ----------------
    hold_err = 0; step_err = 0; strobe_err = 0; le_cnt = 0; le_first = -1; le_second = -1;
    ph = 0; pv = 0; phs = 0; pvs = 0; pvo = 0; pen = 0;
    for (int c = 0; c < 3200; c++) begin
      cyc(1'b1, (c % 2) == 0);
      if (c > 0) begin
        if (pen == 0) begin
          if (int'(h_count) != ph || int'(v_count) != pv || int'(hsync) != phs ||
              int'(vsync) != pvs || int'(video_on) != pvo) hold_err++;
        end else if (int'(h_count) != (ph + 1) % 800) begin
          step_err++;
        end
      end
      if (!pix_en && (line_end || frame_end)) strobe_err++;
      if (line_end) begin
        le_cnt++;
        if (le_first < 0) le_first = c;
        else if (le_second < 0) le_second = c;
      end
      ph = int'(h_count); pv = int'(v_count); phs = int'(hsync);
      pvs = int'(vsync); pvo = int'(video_on); pen = int'(pix_en);
    end
    check_val("toggle_hold_err", hold_err, 0);
    check_val("toggle_step_err", step_err, 0);
    check_val("toggle_strobe_in_idle", strobe_err, 0);
    check_val("toggle_line_end_count", le_cnt, 2);
    check_val("toggle_line_end_period", le_second - le_first, 1600);

    // ---------------- mid-line reset ----------------
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      cyc(1'b1, 1'b1);
      if (h_count == 16'd300) found = 1'b1;
    end
    check_val("reach_h300", found, 1);
    cyc(1'b0, 1'b1);
    check_val("midrst_line_end_gated", line_end, 0);
    cyc(1'b1, 1'b1);
    check_val("midrst_h_count", h_count, 799);
    check_val("midrst_v_count", v_count, 524);
    check_val("midrst_video_on", video_on, 0);
    check_val("midrst_hsync", hsync, 1);
    check_val("midrst_vsync", vsync, 1);
    check_val("midrst_frame_end", frame_end, 1);

    // ---------------- small instance ----------------
    cyc_s(1'b0, 1'b1);
    check_val("s_rst_h", h_s, 11);
    check_val("s_rst_v", v_s, 6);
    check_val("s_rst_hsync", hsync_s, 0);
    check_val("s_rst_vsync", vsync_s, 0);
    check_val("s_rst_video", video_s, 0);
    check_val("s_rst_line_end", line_end_s, 0);

    le_first = -1; le_second = -1; fe_first = -1; fe_second = -1; fe_cnt = 0;
    skew_err = 0; vo_s = 0; vs_cnt = 0; vs_min = 99; vs_max = -1;
    hs_cnt = 0; hs_min = 99; hs_max = -1; h_max = 0; v_max = 0;
    for (int c = 0; c < 200; c++) begin
      cyc_s(1'b1, 1'b1);
      if (c > 0) begin
        exp_hs = (h_s == 8'd9 || h_s == 8'd10);
        exp_vs = (v_s == 8'd5);
        exp_vo = (h_s < 8'd8) && (v_s < 8'd4);
        if (hsync_s !== exp_hs || vsync_s !== exp_vs || video_s !== exp_vo) skew_err++;
      end
      if (int'(h_s) > h_max) h_max = int'(h_s);
      if (int'(v_s) > v_max) v_max = int'(v_s);
      if (c >= 1 && c <= 84) begin
        if (video_s) vo_s++;
        if (hsync_s) hs_cnt++;
        if (vsync_s) begin
          vs_cnt++;
          if (int'(v_s) < vs_min) vs_min = int'(v_s);
          if (int'(v_s) > vs_max) vs_max = int'(v_s);
        end
        if (hsync_s && v_s == 8'd0) begin
          if (int'(h_s) < hs_min) hs_min = int'(h_s);
          if (int'(h_s) > hs_max) hs_max = int'(h_s);
        end
      end
      if (line_end_s) begin
        if (le_first < 0) le_first = c;
        else if (le_second < 0) le_second = c;
      end
      if (frame_end_s) begin
        fe_cnt++;
        if (fe_first < 0) fe_first = c;
        else if (fe_second < 0) fe_second = c;
      end
    end
    check_val("s_first_frame_end_cycle", fe_first, 0);
    check_val("s_frame_end_period", fe_second - fe_first, 84);
    check_val("s_frame_end_count", fe_cnt, 3);
    check_val("s_line_end_period", le_second - le_first, 12);
    check_val("s_hsync_first_h", hs_min, 9);
    check_val("s_hsync_last_h", hs_max, 10);
    check_val("s_hsync_cycles_frame", hs_cnt, 14);
    check_val("s_vsync_line", vs_min, 5);
    check_val("s_vsync_line_last", vs_max, 5);
    check_val("s_vsync_cycles_frame", vs_cnt, 12);
    check_val("s_video_cycles_frame", vo_s, 32);
    check_val("s_decode_skew_err", skew_err, 0);
    check_val("s_h_max", h_max, 11);
    check_val("s_v_max", v_max, 6);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
